// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with round-to-nearest-even.
// One operation at a time: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> OUT, with specials short-cut to OUT.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_ovf,
    output logic         flag_inv,
    output logic         flag_zero
);

    // Working mantissa is {hidden, frac, G, R, S}; the sum adds a carry bit on top.
    localparam int MW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_TOP  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;
    state_t state, state_nxt;

    logic [W-1:0]    a_p0, b_p0;
    logic [1:0]      op_p0;
    logic            sign_p1, sub_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [MW-1:0]   ma_p1, mb_p1;
    logic            sign_p2;
    logic [EXP_W-1:0] exp_p2;
    logic [MW:0]     sum_p2;
    logic            sign_p3, zero_p3;
    logic [EW-1:0]   exp_p3;
    logic [MW-1:0]   man_p3;

    function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m, input logic [EXP_W-1:0] d);
        logic [MW-1:0] r;
        logic          st;
        if (int'(d) >= MW) begin
            r  = '0;
            st = |m;
        end else begin
            r  = m >> d;
            st = |(m & ~({MW{1'b1}} << d));
        end
        r[0] = r[0] | st;
        return r;
    endfunction

    function automatic int lzc(input logic [MW-1:0] m);
        int n;
        n = MW;
        for (int i = 0; i < MW; i++)
            if (m[i]) n = MW - 1 - i;
        return n;
    endfunction

    // Returns {overflow, packed result}.
    function automatic logic [W:0] rne_pack(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
        logic [MAN_W+1:0] mr;
        logic             up;
        logic [EW-1:0]    en;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[MW-1:3]} + (MAN_W+2)'(up);
        en = e;
        if (mr[MAN_W+1]) begin
            mr = mr >> 1;
            en = en + EW'(1);
        end
        if (en >= EXP_TOP)
            return {1'b1, s, EXP_ONES, {MAN_W{1'b0}}};
        return {1'b0, s, en[EXP_W-1:0], mr[MAN_W-1:0]};
    endfunction

    function automatic logic is_zero(input logic [W-1:0] r);
        return r[W-2:0] == '0;
    endfunction

    // ---- ALIGN: unpack, classify, order by magnitude ----
    logic            sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EXP_W-1:0] ea, eb, e_big, e_diff;
    logic [MAN_W-1:0] fa, fb;
    logic            spec_hit, spec_inv, sgn_big, sgn_small;
    logic [W-1:0]    spec_res;
    logic [MW-1:0]   m_big, m_small;

    always_comb begin
        sa = a_p0[W-1];
        ea = a_p0[W-2:MAN_W];
        fa = a_p0[MAN_W-1:0];
        sb = b_p0[W-1] ^ (op_p0 == 2'b01);
        eb = b_p0[W-2:MAN_W];
        fb = b_p0[MAN_W-1:0];
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_res = '0;
        if (op_p0[1] || a_nan || b_nan) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf)
            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else if (b_inf)
            spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        else if (a_zero && b_zero)
            spec_res = {sa & sb, {(W-1){1'b0}}};
        else if (b_zero)
            spec_res = a_p0;
        else if (a_zero)
            spec_res = {sb, b_p0[W-2:0]};
        else
            spec_hit = 1'b0;

        if ({ea, fa} >= {eb, fb}) begin
            sgn_big = sa;  sgn_small = sb;  e_big = ea;  e_diff = ea - eb;
            m_big   = {1'b1, fa, 3'b000};
            m_small = {1'b1, fb, 3'b000};
        end else begin
            sgn_big = sb;  sgn_small = sa;  e_big = eb;  e_diff = eb - ea;
            m_big   = {1'b1, fb, 3'b000};
            m_small = {1'b1, fa, 3'b000};
        end
    end

    // ---- NORM: renormalise the raw sum ----
    logic            norm_sign, norm_zero;
    logic [EW-1:0]   norm_exp;
    logic [MW-1:0]   norm_man;
    int              lz, e_tmp;

    always_comb begin
        norm_sign = sign_p2;
        norm_zero = 1'b0;
        norm_exp  = '0;
        norm_man  = '0;
        lz        = 0;
        e_tmp     = 0;
        if (sum_p2 == '0) begin
            norm_sign = 1'b0;
            norm_zero = 1'b1;
        end else if (sum_p2[MW]) begin
            norm_man = sum_p2[MW:1] | MW'(sum_p2[0]);
            norm_exp = {2'b00, exp_p2} + EW'(1);
        end else begin
            lz       = lzc(sum_p2[MW-1:0]);
            norm_man = sum_p2[MW-1:0] << lz;
            e_tmp    = int'(exp_p2) - lz;
            if (e_tmp <= 0)
                norm_zero = 1'b1;
            else
                norm_exp = EW'(e_tmp);
        end
    end

    // ---- ROUND: RNE and overflow ----
    logic [W:0]   rnd;
    logic [W-1:0] round_res;
    logic         round_ovf;

    always_comb begin
        rnd       = rne_pack(sign_p3, exp_p3, man_p3);
        round_res = zero_p3 ? {sign_p3, {(W-1){1'b0}}} : rnd[W-1:0];
        round_ovf = zero_p3 ? 1'b0 : rnd[W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ALIGN;
            ALIGN:   state_nxt = spec_hit ? OUT : ADD;
            ADD:     state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0 <= '0;  b_p0 <= '0;  op_p0 <= '0;
            sign_p1 <= 1'b0;  sub_p1 <= 1'b0;  exp_p1 <= '0;  ma_p1 <= '0;  mb_p1 <= '0;
            sign_p2 <= 1'b0;  exp_p2 <= '0;  sum_p2 <= '0;
            sign_p3 <= 1'b0;  zero_p3 <= 1'b0;  exp_p3 <= '0;  man_p3 <= '0;
            result <= '0;  flag_ovf <= 1'b0;  flag_inv <= 1'b0;  flag_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_p0  <= a;
                    b_p0  <= b;
                    op_p0 <= op;
                end
                ALIGN: if (spec_hit) begin
                    result    <= spec_res;
                    flag_inv  <= spec_inv;
                    flag_ovf  <= 1'b0;
                    flag_zero <= is_zero(spec_res);
                end else begin
                    sign_p1 <= sgn_big;
                    sub_p1  <= sgn_big ^ sgn_small;
                    exp_p1  <= e_big;
                    ma_p1   <= m_big;
                    mb_p1   <= shr_sticky(m_small, e_diff);
                end
                ADD: begin
                    sum_p2  <= sub_p1 ? ({1'b0, ma_p1} - {1'b0, mb_p1}) : ({1'b0, ma_p1} + {1'b0, mb_p1});
                    sign_p2 <= sign_p1;
                    exp_p2  <= exp_p1;
                end
                NORM: begin
                    sign_p3 <= norm_sign;
                    zero_p3 <= norm_zero;
                    exp_p3  <= norm_exp;
                    man_p3  <= norm_man;
                end
                ROUND: begin
                    result    <= round_res;
                    flag_ovf  <= round_ovf;
                    flag_inv  <= 1'b0;
                    flag_zero <= is_zero(round_res);
                end
                default: ;
            endcase
        end
    end

endmodule
